// File: rtl/inst_queue.sv
// inst_queue: in-order instruction buffer between fetch and decode.
// Holds up to DEPTH (pc, inst) pairs in a circular buffer, hands the oldest
// entry to decode over valid/ready, and empties in one cycle on flush_i.
// Optional macro INST_QUEUE_BYPASS_EN: an empty queue forwards fetch straight
// to decode in the same cycle when decode is ready.
module inst_queue #(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             valid_pre_i,
  output logic             ready_pre_o,
  input  logic [31:0]      pc_i,
  input  logic [31:0]      inst_i,
  output logic             valid_post_o,
  input  logic             ready_post_i,
  output logic [31:0]      pc_o,
  output logic [31:0]      inst_o,
  input  logic             flush_i,
  output logic [PTR_W:0]   count_o
);

  localparam logic [PTR_W:0]   FULL    = DEPTH[PTR_W:0];
  localparam logic [PTR_W:0]   CNT_ONE = {{PTR_W{1'b0}}, 1'b1};
  localparam logic [PTR_W-1:0] PTR_ONE = {{(PTR_W-1){1'b0}}, 1'b1};

  logic [31:0]      pc_mem   [DEPTH];
  logic [31:0]      inst_mem [DEPTH];
  logic [PTR_W-1:0] wptr;
  logic [PTR_W-1:0] rptr;
  logic [PTR_W:0]   count;

  logic not_empty;
  logic bypass;
  logic push;
  logic pop;

  // Handshake decode: ready depends only on registered occupancy, never on decode.
  always_comb begin
    not_empty   = (count != '0);
    ready_pre_o = (count != FULL);
    bypass      = 1'b0;
`ifdef INST_QUEUE_BYPASS_EN
    bypass      = !not_empty && valid_pre_i && ready_post_i && !flush_i;
`endif
    valid_post_o = (not_empty && !flush_i) || bypass;
    pop          = not_empty && !flush_i && ready_post_i;
    push         = valid_pre_i && ready_pre_o && !flush_i && !bypass;
    if (not_empty) begin
      pc_o   = pc_mem[rptr];
      inst_o = inst_mem[rptr];
    end else if (bypass) begin
      pc_o   = pc_i;
      inst_o = inst_i;
    end else begin
      pc_o   = '0;
      inst_o = '0;
    end
    count_o = count;
  end

  // Pointer and occupancy state; flush overrides any push or pop this cycle.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else if (flush_i) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + PTR_ONE;
      if (pop)  rptr <= rptr + PTR_ONE;
      case ({push, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  // Entry storage: written on accepted push, left untouched by flush.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < DEPTH; k++) begin
        pc_mem[k]   <= '0;
        inst_mem[k] <= '0;
      end
    end else if (push) begin
      pc_mem[wptr]   <= pc_i;
      inst_mem[wptr] <= inst_i;
    end
  end

endmodule

// File: tb/tb_inst_queue.sv
// Testbench for inst_queue: directed scenarios followed by random traffic,
// with a scoreboard of expected (pc, inst) pairs popped by an output monitor.
module tb_inst_queue;

  localparam int DEPTH = 4;
  localparam int PTR_W = 2;

  logic             clock = 1'b0;
  logic             reset;
  logic             valid_pre_i;
  logic             ready_pre_o;
  logic [31:0]      pc_i;
  logic [31:0]      inst_i;
  logic             valid_post_o;
  logic             ready_post_i;
  logic [31:0]      pc_o;
  logic [31:0]      inst_o;
  logic             flush_i;
  logic [PTR_W:0]   count_o;

  int errors = 0;
  int checks = 0;

  logic [63:0] sb [$];   // expected {pc, inst} in delivery order
  int          mcount;   // model occupancy
  logic        last_v, last_acc, last_f;
  logic [31:0] last_pc, last_inst;

  inst_queue #(.DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
    .clock(clock), .reset(reset),
    .valid_pre_i(valid_pre_i), .ready_pre_o(ready_pre_o),
    .pc_i(pc_i), .inst_i(inst_i),
    .valid_post_o(valid_post_o), .ready_post_i(ready_post_i),
    .pc_o(pc_o), .inst_o(inst_o),
    .flush_i(flush_i), .count_o(count_o)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One cycle: drive at negedge, check outputs against the model, advance model.
  task automatic step(input logic v, input logic [31:0] p, input logic [31:0] i,
                      input logic r, input logic f);
    logic bp, exp_valid, accept, popm;
    @(negedge clock);
    valid_pre_i = v; pc_i = p; inst_i = i; ready_post_i = r; flush_i = f;
    #1;
    bp = 1'b0;
`ifdef INST_QUEUE_BYPASS_EN
    bp = (mcount == 0) && v && r && !f;
`endif
    exp_valid = ((mcount != 0) && !f) || bp;
    chk("ready_pre", ready_pre_o, mcount != DEPTH);
    chk("valid_post", valid_post_o, exp_valid);
    chk("count", count_o, mcount);
    if (mcount == 0 && !bp) begin
      chk("pc_empty", pc_o, 0);
      chk("inst_empty", inst_o, 0);
    end
    accept = v && (mcount != DEPTH) && !f;
    popm   = (mcount != 0) && r && !f;
    if (f) begin
      sb.delete();
      mcount = 0;
    end else begin
      if (accept) sb.push_back({p, i});
      if (accept && !bp) mcount++;
      if (popm) mcount--;
    end
    last_v = v; last_acc = accept; last_f = f; last_pc = p; last_inst = i;
  endtask

  // Output monitor: every decode handshake must deliver the oldest expected entry.
  initial begin
    logic [63:0] e;
    forever begin
      @(negedge clock);
      #2;
      if (!reset && valid_post_o && ready_post_i) begin
        if (sb.size() == 0) begin
          chk("unexpected_pop", {pc_o, inst_o}, 64'h0);
          if ({pc_o, inst_o} == 64'h0) begin
            errors++;
            $display("FAIL unexpected_pop: got an entry, expected none at %0t", $time);
          end
        end else begin
          e = sb.pop_front();
          chk("pop_pc", pc_o, e[63:32]);
          chk("pop_inst", inst_o, e[31:0]);
        end
      end
    end
  end

  initial begin
    logic v, r, f;
    logic [31:0] p, i;
    reset = 1'b1; valid_pre_i = 0; pc_i = 0; inst_i = 0; ready_post_i = 0; flush_i = 0;
    mcount = 0; last_v = 0; last_acc = 0; last_f = 0; last_pc = 0; last_inst = 0;
    #1;
    chk("rst_ready", ready_pre_o, 1);
    chk("rst_valid", valid_post_o, 0);
    chk("rst_pc", pc_o, 0);
    chk("rst_count", count_o, 0);
    @(negedge clock); @(negedge clock);
    reset = 1'b0;

    // First push with decode stalled: visible one cycle later.
    step(1, 32'h8000_0000, 32'h0000_0413, 0, 0);
    step(0, 0, 0, 0, 0);
    chk("first_pc", pc_o, 32'h8000_0000);
    chk("first_inst", inst_o, 32'h0000_0413);
    chk("first_count", count_o, 1);

    // Fill to DEPTH, hold a 5th request until a pop frees a slot.
    for (int k = 1; k < 4; k++) step(1, 32'h8000_0000 + 4 * k, 32'h13 + k, 0, 0);
    step(1, 32'h8000_0010, 32'h99, 0, 0);
    chk("full_count", count_o, 4);
    chk("full_ready", ready_pre_o, 0);
    step(1, 32'h8000_0010, 32'h99, 1, 0);   // pop only, push blocked while full
    step(1, 32'h8000_0010, 32'h99, 0, 0);   // freed slot now accepted
    for (int k = 0; k < 4; k++) step(0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0);

    // Three entries, then simultaneous push/pop across pointer wrap.
    for (int k = 0; k < 3; k++) step(1, 32'h8000_0100 + 4 * k, 32'h200 + k, 0, 0);
    for (int k = 3; k < 9; k++) step(1, 32'h8000_0100 + 4 * k, 32'h200 + k, 1, 0);
    step(0, 0, 0, 0, 0);
    chk("pp_count", count_o, 3);

    // Flush with push and pop requested in the same cycle.
    step(1, 32'hdead_0000, 32'hbad, 1, 1);
    step(0, 0, 0, 0, 0);
    chk("flush_count", count_o, 0);
    chk("flush_ready", ready_pre_o, 1);
    chk("flush_valid", valid_post_o, 0);

    // Asynchronous reset mid-operation with two entries held.
    step(1, 32'h8000_0200, 32'h1, 0, 0);
    step(1, 32'h8000_0204, 32'h2, 0, 0);
    step(0, 0, 0, 0, 0);
    #3 reset = 1'b1;
    #1;
    chk("mid_rst_count", count_o, 0);
    chk("mid_rst_valid", valid_post_o, 0);
    chk("mid_rst_pc", pc_o, 0);
    sb.delete(); mcount = 0;
    @(negedge clock); reset = 1'b0;

    // Push into an empty queue with decode ready.
    step(1, 32'h8000_0300, 32'h0010_0073, 1, 0);
`ifdef INST_QUEUE_BYPASS_EN
    chk("byp_count", count_o, 0);
`else
    step(0, 0, 0, 1, 0);
`endif
    step(0, 0, 0, 0, 0);

    // Random traffic honouring the fetch hold rule.
    for (int n = 0; n < 400; n++) begin
      f = ($urandom_range(0, 19) == 0);
      r = $urandom_range(0, 1);
      if (last_v && !last_acc && !last_f) begin
        v = 1; p = last_pc; i = last_inst;
      end else begin
        v = ($urandom_range(0, 9) < 7);
        p = $urandom; i = $urandom;
      end
      step(v, p, i, r, f);
    end
    for (int n = 0; n < 6; n++) step(0, 0, 0, 1, 0);
    chk("drain_sb", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/inst_queue.md
Name: inst_queue

Overview:
- Instruction buffer between the fetch stage and the decode stage.
- Accepts (pc, inst) pairs from the fetch valid/ready output and holds up to DEPTH entries in order.
- Presents the oldest entry to decode on a valid/ready handshake.
- Discards all contents in one cycle on a redirect flush from the back end.

Parameters:
- DEPTH, 4: number of entries. Must be a power of two, ≥2.
- PTR_W, 2: pointer width, equal to log2(DEPTH).

Ports:
- clock  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- valid_pre_i  input  1  fetch has an instruction on pc_i/inst_i.
- ready_pre_o  output  1  queue can accept an entry this cycle.
- pc_i  input  32  PC from fetch.
- inst_i  input  32  instruction word from fetch.
- valid_post_o  output  1  head entry valid for decode.
- ready_post_i  input  1  decode accepts the head entry.
- pc_o  output  32  head entry PC.
- inst_o  output  32  head entry instruction.
- flush_i  input  1  redirect; discard all entries.
- count_o  output  PTR_W+1  current occupancy, 0..DEPTH.

Behaviour:
- Reset (async, active-high): wptr=0, rptr=0, count=0, all storage zeroed. Outputs during reset: ready_pre_o=1, valid_post_o=0, pc_o=0, inst_o=0, count_o=0.
- Storage: circular buffer. wptr and rptr wrap modulo DEPTH (natural PTR_W-bit overflow). count is held separately, PTR_W+1 bits wide.
- ready_pre_o = (count != DEPTH), driven from registered state only. It has no combinational path from ready_post_i.
- valid_post_o = (count != 0) && !flush_i.
- pc_o and inst_o come combinationally from mem[rptr] when count != 0, and are 0 when empty.
- push = valid_pre_i && ready_pre_o && !flush_i. Writes mem[wptr] and increments wptr.
- pop = valid_post_o && ready_post_i. Increments rptr.
- count update:
  - push only: +1.
  - pop only: −1.
  - push and pop together: unchanged.
  - neither: unchanged.
- Full (count=DEPTH): ready_pre_o=0, so no push, even if a pop happens in the same cycle. The freed slot becomes visible to fetch on the next cycle.
- Empty (count=0): no pop. Latency from push to valid_post_o is 1 cycle (the Optional Feature modifies this).
- Flush:
  - When flush_i=1, the next edge sets wptr=0, rptr=0, count=0.
  - Any push or pop requested in the flush cycle is dropped.
  - Storage contents are not cleared.
  - Flush has priority over all other events.
- Fetch must hold pc_i/inst_i stable while valid_pre_i=1 and ready_pre_o=0. Decode may drop ready_post_i at any time.
- count_o mirrors the count register.

Optional Feature:
- Macro: INST_QUEUE_BYPASS_EN.
- Defined: when count=0, valid_pre_i=1, ready_post_i=1 and flush_i=0:
  - valid_post_o=1, pc_o=pc_i, inst_o=inst_i in the same cycle.
  - The entry is consumed by decode and not written into storage.
  - wptr, rptr and count are unchanged.
  - This gives zero-cycle latency through an empty queue.
- Not defined: no combinational path from the fetch side to the decode side. Minimum latency is 1 cycle, per Behaviour.

Test Plan:
- Reset, then push pc=0x80000000 inst=0x00000413 with ready_post_i=0 → next cycle valid_post_o=1, pc_o=0x80000000, inst_o=0x00000413, count_o=1.
- Push 4 entries (pc 0x80000000..0x8000000C) with ready_post_i=0 → count_o=4, ready_pre_o=0. A 5th valid_pre_i is held off, and pc_i stays stable until a pop frees a slot.
- Fill to 3 entries, then drive push and pop together for 6 cycles → count_o stays 3. Popped PCs appear in push order across pointer wrap-around.
- With 3 entries, assert flush_i together with valid_pre_i=1 and ready_post_i=1 → valid_post_o=0 that cycle. Next cycle count_o=0, ready_pre_o=1, and no entry from the flush cycle remains.
- Assert reset mid-operation with count=2 → count_o=0, valid_post_o=0, pc_o=0 immediately, before the next clock edge.
- INST_QUEUE_BYPASS_EN: empty queue, push inst=0x00100073 with ready_post_i=1 → valid_post_o=1 and inst_o=0x00100073 in the same cycle, count_o stays 0. Without the macro, valid_post_o rises one cycle later.
